// File: rtl/vedic_mult_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2x2 Vedic cell, one digit pair per cycle.
// Optional ZERO_SKIP_EN: a zero operand bypasses the digit loop and goes straight to DONE.
module vedic_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned NDIG = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CW   = (NDIG > 2) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_chk
    $error("vedic_mult_seq: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  // Current digit pair, its partial product and the weighted contribution
  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [3:0]        pp;
  logic [CW:0]       dsum;
  logic [PW-1:0]     pp_sh, acc_sum;

  assign a_sh    = a_q >> {i_q, 1'b0};
  assign b_sh    = b_q >> {j_q, 1'b0};
  assign dsum    = {1'b0, i_q} + {1'b0, j_q};
  assign pp_sh   = PW'(pp) << {dsum, 1'b0};
  assign acc_sum = acc_q + pp_sh;

  VedicMultiplier_2x2 u_cell (
    .a (a_sh[1:0]),
    .b (b_sh[1:0]),
    .p (pp)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    i_d         = i_q;
    j_d         = j_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a_in;
          b_d        = b_in;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          state_d    = S_CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef ZERO_SKIP_EN
          if (a_in == '0 || b_in == '0) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            prod_d      = '0;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            prod_d      = acc_sum;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = prod_q;
  assign busy      = busy_q;

endmodule

// 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier cell.
module VedicMultiplier_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule
